// File: rtl/mmio_bus.sv
// Data-side bridge for the CPU MEM stage: routes accesses to data memory or to the
// MMIO page (LED, button-capture latch, output FIFO, cycle counter).
module mmio_bus #(
    parameter int          DM_AW     = 8,
    parameter int          OUT_DEPTH = 4,
    parameter logic [23:0] MMIO_PAGE = 24'h00007F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      mem_addr,
    input  logic             mem_we,
    input  logic [31:0]      mem_din,
    output logic [31:0]      mem_dout,
    output logic [DM_AW-1:0] dm_addr,
    output logic             dm_we,
    output logic [31:0]      dm_din,
    input  logic [31:0]      dm_dout,
    input  logic [15:0]      sw,
    input  logic             btn,
    output logic [15:0]      led,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int         PW     = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam logic [4:0] DEPTH5 = 5'(OUT_DEPTH);

    logic        is_mmio, mmio_wr;
    logic [7:0]  off;
    logic [31:0] mmio_rdata;

    logic [15:0]   led_q, led_d;
    logic [15:0]   sw_m_q, sw_s_q;
    logic          btn_m_q, btn_s_q, btn_d_q;
    logic [15:0]   in_data_q, in_data_d;
    logic          in_valid_q, in_valid_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   cyc_q;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [4:0]    count_q, count_d;
    logic [31:0]   fifo_mem [OUT_DEPTH];

    logic btn_rise, push_req, pop, full, empty, push_ok;

    assign is_mmio  = (mem_addr[31:8] == MMIO_PAGE);
    assign off      = mem_addr[7:0];
    assign mmio_wr  = is_mmio & mem_we;
    assign dm_we    = mem_we & ~is_mmio;
    assign dm_addr  = mem_addr[DM_AW+1:2];
    assign dm_din   = mem_din;
    assign mem_dout = is_mmio ? mmio_rdata : dm_dout;

    assign btn_rise  = btn_s_q & ~btn_d_q;
    assign empty     = (count_q == 5'd0);
    assign full      = (count_q == DEPTH5);
    assign out_valid = ~empty;
    assign out_data  = fifo_mem[rd_ptr_q];
    assign led       = led_q;
    assign push_req  = mmio_wr & (off == 8'h00);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok   = push_req & (~full | pop);

    always_comb begin
        mmio_rdata = 32'h0;
        case (off)
            8'h04:   mmio_rdata = {24'h0, count_q, ovf_q, empty, full};
            8'h08:   mmio_rdata = {31'h0, in_valid_q};
            8'h0C:   mmio_rdata = {16'h0, in_data_q};
            8'h10:   mmio_rdata = {16'h0, led_q};
            8'h14:   mmio_rdata = cyc_q;
            default: mmio_rdata = 32'h0;
        endcase
    end

    always_comb begin
        led_d      = led_q;
        in_data_d  = in_data_q;
        in_valid_d = in_valid_q;
        ovf_d      = ovf_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (mmio_wr && off == 8'h10) led_d = mem_din[15:0];

        // Ordering makes a capture override a same-cycle clear, and an overflow a same-cycle ovf clear.
        if (mmio_wr && off == 8'h08) in_valid_d = 1'b0;
        if (btn_rise && !in_valid_q) begin
            in_data_d  = sw_s_q;
            in_valid_d = 1'b1;
        end

        if (mmio_wr && off == 8'h04) ovf_d = 1'b0;
        if (push_req && !push_ok)    ovf_d = 1'b1;

        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led_q      <= '0;
            sw_m_q     <= '0;
            sw_s_q     <= '0;
            btn_m_q    <= 1'b0;
            btn_s_q    <= 1'b0;
            btn_d_q    <= 1'b0;
            in_data_q  <= '0;
            in_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
            cyc_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            led_q      <= led_d;
            sw_m_q     <= sw;
            sw_s_q     <= sw_m_q;
            btn_m_q    <= btn;
            btn_s_q    <= btn_m_q;
            btn_d_q    <= btn_s_q;
            in_data_q  <= in_data_d;
            in_valid_q <= in_valid_d;
            ovf_q      <= ovf_d;
            cyc_q      <= cyc_q + 32'd1;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage is intentionally left out of reset; out_valid gates its contents.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= mem_din;
    end
endmodule
